// File: rtl/tolower_stream.sv
// ---------------------------------------------------------------------------
// tolower_stream
//
// Purpose:
//   Streaming ASCII lower-caser with a small elastic buffer. Each accepted
//   byte in 'A'..'Z' (0x41..0x5A) is converted to its lowercase form (+0x20).
//   Every other byte passes through unchanged. Converted bytes are queued in
//   a DEPTH-entry FIFO and presented downstream with a valid/ready handshake.
//
// Parameters:
//   DEPTH      - number of FIFO entries (power of two, >= 2), default 4
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst        - synchronous active-high reset, clears FIFO and counter
//   in_valid   - upstream byte present
//   in_ready   - block can accept a byte this cycle (occupancy < DEPTH)
//   in_char    - upstream ASCII byte
//   out_valid  - converted byte present (occupancy > 0)
//   out_ready  - downstream accepts the byte this cycle
//   out_char   - converted byte, taken straight from the FIFO head entry
//   out_conv   - high when out_char was converted from uppercase
//   conv_count - saturating count of uppercase bytes pushed
//                (only present when TOLOWER_COUNT_EN is defined)
//
// Build option:
//   TOLOWER_COUNT_EN - define to add the conv_count port and its counter.
// ---------------------------------------------------------------------------
module tolower_stream #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_char,
`ifdef TOLOWER_COUNT_EN
    output logic        out_conv,
    output logic [15:0] conv_count
`else
    output logic        out_conv
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Pointer wrap relies on natural AW-bit overflow, so DEPTH must be a
    // power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tolower_stream: DEPTH must be a power of two and at least 2");
    end

    // Each FIFO entry holds {conv bit, converted byte}.
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic       push;
    logic       pop;
    logic       in_upper;
    logic [7:0] in_lower;

    // Conversion of the incoming byte and the handshake qualifiers. in_ready
    // depends only on stored occupancy, never on out_ready.
    always_comb begin
        in_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
        in_lower  = in_upper ? (in_char + 8'h20) : in_char;
        in_ready  = (count_q < DEPTH_C);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Outputs come from the head entry only, so there is no path from
    // in_char to out_char and the head holds while the consumer stalls.
    always_comb begin
        out_char = mem_q[rd_ptr_q][7:0];
        out_conv = mem_q[rd_ptr_q][8];
    end

    // Next-state for storage, pointers and occupancy. A push and a pop in
    // the same cycle cancel in the occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_upper, in_lower};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register. Storage is cleared too so the head reads 0x00 right
    // after reset and stale bytes can never resurface.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef TOLOWER_COUNT_EN
    logic [15:0] conv_cnt_q, conv_cnt_d;

    // Saturating count of uppercase bytes actually accepted.
    always_comb begin
        conv_cnt_d = conv_cnt_q;
        if (push && in_upper && (conv_cnt_q != 16'hFFFF)) begin
            conv_cnt_d = conv_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_cnt_q <= '0;
        end else begin
            conv_cnt_q <= conv_cnt_d;
        end
    end

    assign conv_count = conv_cnt_q;
`endif

endmodule

// File: tb/tb_tolower_stream.sv
// ---------------------------------------------------------------------------
// tb_tolower_stream
//
// Directed self-checking bench for tolower_stream (DEPTH = 4). Inputs are
// driven 1 time unit after each rising edge and outputs are compared at the
// same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_tolower_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        out_conv;
`ifdef TOLOWER_COUNT_EN
    logic [15:0] conv_count;
`endif

    int errors = 0;
    int checks = 0;

    tolower_stream #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
`ifdef TOLOWER_COUNT_EN
        .out_conv   (out_conv),
        .conv_count (conv_count)
`else
        .out_conv   (out_conv)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset puts the block into the documented idle state.
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_char !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_char got=%02h exp=00", out_char); end
        checks++; if (out_conv !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_conv got=%0b exp=0", out_conv); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
`ifdef TOLOWER_COUNT_EN
        checks++; if (conv_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_conv_count got=%04h exp=0000", conv_count); end
`endif
    endtask

    // in_char is don't-care while in_valid is low.
    task automatic test_ignore_invalid();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_char = 8'h41 + 8'(i);
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ignore_invalid[%0d] out_valid got=%0b exp=0", i, out_valid); end
        end
    endtask

    // Single uppercase byte through an empty block: one-cycle latency.
    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; in_char = 8'h41;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; in_char = 8'h00;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_char !== 8'h61) begin errors++; $display("[TB] FAIL single_out_char got=%02h exp=61", out_char); end
        checks++; if (out_conv !== 1'b1) begin errors++; $display("[TB] FAIL single_out_conv got=%0b exp=1", out_conv); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got=%0b exp=0", out_valid); end
    endtask

    // Bytes on either side of the 'A'..'Z' range, streamed back to back.
    task automatic test_boundary();
        logic [7:0] vin  [5] = '{8'h40, 8'h5A, 8'h5B, 8'h7A, 8'hC1};
        logic [7:0] vout [5] = '{8'h40, 8'h7A, 8'h5B, 8'h7A, 8'hC1};
        logic       vcnv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                in_valid = 1'b1; in_char = vin[i];
            end else begin
                in_valid = 1'b0; in_char = 8'h00;
            end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_char !== vout[i-1] || out_conv !== vcnv[i-1]) begin
                    errors++;
                    $display("[TB] FAIL boundary[%0d] got=%0b/%02h/%0b exp=1/%02h/%0b", i-1, out_valid, out_char, out_conv, vout[i-1], vcnv[i-1]);
                end
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL boundary_drained got=%0b exp=0", out_valid); end
    endtask

    // Fill under backpressure, observe full, then drain in order.
    task automatic test_backpressure();
        logic [7:0] vin  [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        logic [7:0] vout [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_char = vin[i];
            #1;
            checks++; if (in_ready !== (i < 4)) begin errors++; $display("[TB] FAIL bp_in_ready[%0d] got=%0b exp=%0b", i, in_ready, (i < 4)); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_char !== 8'h68) begin errors++; $display("[TB] FAIL bp_hold[%0d] got=%0b/%02h exp=1/68", i, out_valid, out_char); end
            end
            tick();
        end
        // in_valid stays up with 0x4F until the handshake completes.
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            if (j == 0) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got=%0b exp=0", in_ready); end
            end
            if (j == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_rise got=%0b exp=1", in_ready); end
            end
            checks++; if (out_valid !== 1'b1 || out_char !== vout[j] || out_conv !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_drain[%0d] got=%0b/%02h/%0b exp=1/%02h/1", j, out_valid, out_char, out_conv, vout[j]);
            end
            tick();
            if (j == 1) begin
                in_valid = 1'b0; in_char = 8'h00;
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got=%0b exp=0", out_valid); end
    endtask

    // Occupancy held at 3 with push+pop every cycle; pointers wrap twice.
    task automatic test_back_to_back();
        logic [7:0] vfill [3]  = '{8'h41, 8'h62, 8'h43};
        logic [7:0] vin   [10] = '{8'h44, 8'h65, 8'h46, 8'h67, 8'h48,
                                   8'h69, 8'h4A, 8'h6B, 8'h4C, 8'h6D};
        logic [7:0] vout  [13] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67,
                                   8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h6D};
        logic       vcnv  [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_char = vfill[i];
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k < 10) begin
                in_valid = 1'b1; in_char = vin[k];
            end else begin
                in_valid = 1'b0; in_char = 8'h00;
            end
            #1;
            if (k < 10) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d] got=%0b exp=1", k, in_ready); end
            end
            checks++; if (out_valid !== 1'b1 || out_char !== vout[k] || out_conv !== vcnv[k]) begin
                errors++;
                $display("[TB] FAIL b2b_out[%0d] got=%0b/%02h/%0b exp=1/%02h/%0b", k, out_valid, out_char, out_conv, vout[k], vcnv[k]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got=%0b exp=0", out_valid); end
    endtask

    // Reset with three bytes buffered; nothing old may come out afterwards.
    task automatic test_reset_midstream();
        logic [7:0] vin [3] = '{8'h51, 8'h52, 8'h53};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_char = vin[i];
            tick();
        end
        // Handshakes offered during the reset cycle must not take effect.
        rst = 1'b1; in_valid = 1'b1; in_char = 8'h54; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_ready got=%0b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale[%0d] got=%0b/%02h exp=0", i, out_valid, out_char); end
        end
        in_valid = 1'b1; in_char = 8'h5A;
        tick();
        in_valid = 1'b0; in_char = 8'h00;
        checks++; if (out_valid !== 1'b1 || out_char !== 8'h7A) begin errors++; $display("[TB] FAIL rstmid_fresh got=%0b/%02h exp=1/7a", out_valid, out_char); end
        tick();
    endtask

`ifdef TOLOWER_COUNT_EN
    // Counter increments only on uppercase pushes and saturates.
    task automatic test_counter();
        logic [7:0] vin [3] = '{8'h4D, 8'h6D, 8'h4D};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_char = vin[i];
            tick();
        end
        in_valid = 1'b0; in_char = 8'h00;
        tick();
        checks++; if (conv_count !== 16'd2) begin errors++; $display("[TB] FAIL count_two got=%04h exp=0002", conv_count); end
        force dut.conv_cnt_q = 16'hFFFF;
        #1;
        release dut.conv_cnt_q;
        in_valid = 1'b1; in_char = 8'h41;
        tick();
        in_valid = 1'b0; in_char = 8'h00;
        tick();
        checks++; if (conv_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL count_sat got=%04h exp=ffff", conv_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_ignore_invalid();
        test_single();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
`ifdef TOLOWER_COUNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
